// File: rtl/fpu_op_sequencer.sv
// LM32 FPU front-end: accepts one FP op, dispatches it to the adder or
// multiplier, waits under a watchdog and returns a one-cycle result.
module fpu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_opcode,
  input  logic [DATA_W-1:0] req_op_a,
  input  logic [DATA_W-1:0] req_op_b,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              add_start,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic              add_done,
  input  logic [DATA_W-1:0] add_res,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_res
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [DATA_W-1:0] QNAN =
    DATA_W'(32'h7FC0_0000);
  localparam logic [CNT_W-1:0] WD_MAX =
    CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_n;
  logic              sel_mul;
  logic [CNT_W-1:0]  wd;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [DATA_W-1:0] add_a_q;
  logic [DATA_W-1:0] add_b_q;
  logic [DATA_W-1:0] mul_a_q;
  logic [DATA_W-1:0] mul_b_q;

  logic              accept;
  logic              is_add;
  logic              is_sub;
  logic              is_mul;
  logic              is_bad;
  logic              done_hit;
  logic              timeout;
  logic [DATA_W-1:0] b_neg;

  assign b_neg = {~req_op_b[DATA_W-1],
                  req_op_b[DATA_W-2:0]};

  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    is_mul = 1'b0;
    is_bad = 1'b0;
    unique case (1'b1)
      (req_opcode == 2'd0): is_add = 1'b1;
      (req_opcode == 2'd1): is_sub = 1'b1;
      (req_opcode == 2'd2): is_mul = 1'b1;
      default:              is_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    done_hit = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = is_bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        done_hit = sel_mul ? mul_done : add_done;
        timeout  = (wd == WD_LAST);
        if (done_hit || timeout) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      sel_mul <= 1'b0;
      wd      <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (is_bad) begin
          data_q <= QNAN;
          err_q  <= 1'b1;
        end else if (is_mul) begin
          sel_mul <= 1'b1;
          mul_a_q <= req_op_a;
          mul_b_q <= req_op_b;
        end else begin
          sel_mul <= 1'b0;
          add_a_q <= req_op_a;
          add_b_q <= is_sub ? b_neg : req_op_b;
        end
      end
      // watchdog saturates so a stuck unit never wraps it
      if (state == S_ISSUE) begin
        wd <= '0;
      end else if (state == S_WAIT && wd != WD_MAX) begin
        wd <= wd + 1'b1;
      end
      if (done_hit) begin
        data_q <= sel_mul ? mul_res : add_res;
        err_q  <= 1'b0;
      end else if (timeout) begin
        data_q <= QNAN;
        err_q  <= 1'b1;
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign add_start  = (state == S_ISSUE) && !sel_mul;
  assign mul_start  = (state == S_ISSUE) && sel_mul;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

  logic unused;
  assign unused = is_add;

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Front-end controller for the LM32 floating-point coprocessor.
- Accepts one FP instruction at a time from the CPU custom-instruction path (valid/ready).
- Decodes the opcode and dispatches the operands to the shared multi-cycle adder unit or multiplier unit (start/done handshake).
- Waits for completion and returns a one-cycle result pulse to the CPU, with a watchdog timeout and illegal-opcode reporting.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single precision)
- TIMEOUT, 64, max cycles in WAIT before abort (>=2)
- CNT_W, 7, watchdog counter width (must hold TIMEOUT)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  CPU presents an instruction
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_opcode  in  2  0=ADD, 1=SUB, 2=MUL, 3=illegal
- req_op_a  in  DATA_W  operand A
- req_op_b  in  DATA_W  operand B
- resp_valid  out  1  one-cycle result pulse
- resp_data  out  DATA_W  result word
- resp_err  out  1  qualifies resp_valid: illegal opcode or timeout
- add_start  out  1  one-cycle start pulse to adder
- add_a, add_b  out  DATA_W each  adder operands
- add_done  in  1  adder result valid (one cycle)
- add_res  in  DATA_W  adder result
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a, mul_b  out  DATA_W each  multiplier operands
- mul_done  in  1  multiplier result valid (one cycle)
- mul_res  in  DATA_W  multiplier result

Behaviour:
- Reset (nrst=0, asynchronous, any state):
  - state=IDLE, all outputs 0 except req_ready=1.
  - Operand registers 0, watchdog 0.
  - An in-flight operation is discarded; no resp_valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; accept on req_valid&req_ready (cycle 0).
  - Latch opcode and operands; select unit: ADD/SUB -> adder, MUL -> multiplier.
  - SUB: latched operand B has bit[DATA_W-1] inverted. All other bits are passed unchanged, including NaN/zero.
  - Opcode 3 -> RESP directly with resp_err=1, resp_data=32'h7FC00000.
- ISSUE (cycle 1):
  - Assert the selected unit's start for exactly one cycle; add_*/mul_* operands driven from the latched registers.
  - Unused unit operand outputs hold their previous value.
  - Then -> WAIT with watchdog cleared.
- WAIT:
  - Watchdog increments each cycle.
  - Selected unit's done -> capture its res, -> RESP, err=0.
  - A done from the non-selected unit is ignored.
  - Watchdog reaches TIMEOUT with no done -> RESP, err=1, data=32'h7FC00000.
  - done and timeout in the same cycle: done wins.
- RESP:
  - resp_valid=1 for exactly one cycle with resp_data/resp_err; -> IDLE.
  - resp_data holds its value until the next RESP; resp_err is meaningful only with resp_valid.
- Latency:
  - Unit with done latency L cycles after start: accept at cycle 0, start at cycle 1, done at cycle 1+L, resp_valid at cycle 2+L.
  - Illegal opcode: resp_valid at cycle 1.
- req_ready=0 in ISSUE/WAIT/RESP; a held req_valid is accepted in the first IDLE cycle after RESP. Back-to-back issue gap is one cycle.
- Any done arriving while not in WAIT (e.g. late done after timeout) is ignored and must not corrupt resp_data.
- No internal arithmetic beyond the SUB sign flip and the watchdog counter, which saturates at TIMEOUT.

Test Plan:
1. MUL: A=32'h40200000 (2.5), B=32'h40000000 (2.0); model returns 32'h40A00000 after L=3 -> mul_start at cycle 1 with mul_a/mul_b as given; resp_valid at cycle 5, data=32'h40A00000, err=0; add_start never asserted.
2. SUB: A=B=32'h3F800000 (1.0) -> add_b=32'hBF800000, add_a=32'h3F800000; model returns 32'h00000000 -> resp_data=0, err=0.
3. Illegal opcode 3 -> resp_valid at cycle 1, err=1, data=32'h7FC00000; no start pulses.
4. Timeout: MUL issued, model never asserts done, TIMEOUT=64 -> resp_valid with err=1, data=32'h7FC00000 exactly 64 cycles after entering WAIT. A late mul_done with 32'h12345678 is then ignored: no extra resp_valid, resp_data unchanged.
5. Back-to-back with req_valid held: ADD 1.0+1.0 (model returns 32'h40000000, L=1) then MUL -> second accept occurs one cycle after the first resp_valid; both responses correct and in order.
6. Reset mid-operation: nrst low during WAIT, then released -> outputs at reset values immediately; the pending done is ignored; no resp_valid; req_ready=1 on the first cycle after release.
